// File: rtl/sm_run_pkg.sv
// Shared command codes, state encodings and helpers for the schoolMIPS debug run controller.
// Used by sm_run_ctrl and, when SM_RUN_CTRL_BREAK_EN is defined, by sm_run_bp.
package sm_run_pkg;

   typedef enum logic [1:0] {
      CMD_CLR  = 2'b00,
      CMD_RUN  = 2'b01,
      CMD_HALT = 2'b10,
      CMD_STEP = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_HALTED = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10
   } state_e;

   // True in the states where the core is allowed to advance on a tick.
   function automatic logic is_active(input state_e s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage

// File: rtl/sm_run_bp.sv
// Breakpoint comparator with resume-skip flag and sticky hit flag.
// Instantiated by sm_run_ctrl only when SM_RUN_CTRL_BREAK_EN is defined.
module sm_run_bp
   import sm_run_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_bp_addr,
   input  logic        i_bp_en,
   input  state_e      i_state,
   input  logic        i_tick,
   input  logic        i_cpu_en,
   input  logic        i_resume,
   output logic        o_break_block,
   output logic        o_bp_hit
);

   logic r_skip;
   logic r_bp_hit;

   // The skip flag lets a resume step over the breakpoint it stopped on.
   assign o_break_block = i_bp_en && (i_pc == i_bp_addr) && is_active(i_state) && !r_skip;
   assign o_bp_hit      = r_bp_hit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_skip   <= 1'b0;
         r_bp_hit <= 1'b0;
      end else begin
         if (i_resume)
            r_skip <= 1'b1;
         else if (i_cpu_en)
            r_skip <= 1'b0;

         if (i_resume)
            r_bp_hit <= 1'b0;
         else if (o_break_block && i_tick)
            r_bp_hit <= 1'b1;
      end
   end

endmodule

// File: rtl/sm_run_ctrl.sv
// Debug run controller: turns divider ticks into CPU clock enables under RUN/HALT/STEP control.
// Optional breakpoint support is compiled in with `define SM_RUN_CTRL_BREAK_EN.
module sm_run_ctrl
   import sm_run_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int CYC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             cmd_ready,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             step_done,
   output logic [CYC_W-1:0] cycles
`ifdef SM_RUN_CTRL_BREAK_EN
   ,
   input  logic [31:0]      pc,
   input  logic [31:0]      bp_addr,
   input  logic             bp_en,
   output logic             bp_hit
`endif
);

   // Handshake: cmd_ready is always 1, so any cycle with cmd_valid=1 is an
   // accepted command; its effect appears after the following clock edge.

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_step_cnt;
   logic [CYC_W-1:0] r_cycles;
   logic             r_step_done;

   cmd_e w_cmd;
   logic w_cmd_clr;
   logic w_cmd_run;
   logic w_cmd_halt;
   logic w_cmd_step;
   logic w_step_zero;
   logic w_step_last;
   logic w_break_block;
   logic w_break_stop;
   logic w_cpu_en;

   assign w_cmd       = cmd_e'(cmd);
   assign w_cmd_clr   = cmd_valid && (w_cmd == CMD_CLR);
   assign w_cmd_run   = cmd_valid && (w_cmd == CMD_RUN);
   assign w_cmd_halt  = cmd_valid && (w_cmd == CMD_HALT);
   assign w_cmd_step  = cmd_valid && (w_cmd == CMD_STEP);
   assign w_step_zero = (cmd_count == '0);
   assign w_step_last = (r_state == ST_STEP) && w_cpu_en && (r_step_cnt == CNT_W'(1));

`ifdef SM_RUN_CTRL_BREAK_EN
   sm_run_bp u_bp (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pc          (pc),
      .i_bp_addr     (bp_addr),
      .i_bp_en       (bp_en),
      .i_state       (r_state),
      .i_tick        (tick),
      .i_cpu_en      (w_cpu_en),
      .i_resume      (w_cmd_run || w_cmd_step),
      .o_break_block (w_break_block),
      .o_bp_hit      (bp_hit)
   );
   assign w_break_stop = w_break_block && tick;
`else
   assign w_break_block = 1'b0;
   assign w_break_stop  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_HALTED;
      else
         r_state <= w_state_nxt;
   end

   // Commands override the internal stop conditions of the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      if (w_step_last || w_break_stop)
         w_state_nxt = ST_HALTED;
      if (w_cmd_run)
         w_state_nxt = ST_RUN;
      else if (w_cmd_halt)
         w_state_nxt = ST_HALTED;
      else if (w_cmd_step)
         w_state_nxt = w_step_zero ? ST_HALTED : ST_STEP;
   end

   always_comb begin
      w_cpu_en = tick && is_active(r_state) && !w_break_block;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step_cnt  <= '0;
         r_cycles    <= '0;
         r_step_done <= 1'b0;
      end else begin
         if (w_cmd_step)
            r_step_cnt <= cmd_count;
         else if (w_cmd_run || w_cmd_halt)
            r_step_cnt <= '0;
         else if ((r_state == ST_STEP) && w_cpu_en)
            r_step_cnt <= r_step_cnt - CNT_W'(1);

         if (w_cmd_clr)
            r_cycles <= '0;
         else if (w_cpu_en)
            r_cycles <= r_cycles + CYC_W'(1);

         r_step_done <= w_step_last || (w_cmd_step && w_step_zero);
      end
   end

   assign cmd_ready = 1'b1;
   assign cpu_en    = w_cpu_en;
   assign state     = r_state;
   assign step_done = r_step_done;
   assign cycles    = r_cycles;

endmodule
